// File: rtl/passcode_checker.sv
// Keypad passcode checker: buffers BCD digits, compares against the stored passcode and
// commits a new one on leaving password-reset. Optional idle timeout: PASSCODE_TIMEOUT_EN.
module passcode_checker #(
   parameter int                    MAX_DIGITS  = 8,
   parameter int                    MIN_LEN     = 4,
   parameter logic [4*MAX_DIGITS-1:0] DEFAULT_PW = 32'h0000_1234,
   parameter int                    DEFAULT_LEN = 4
`ifdef PASSCODE_TIMEOUT_EN
   ,
   parameter int                    TIMEOUT_CYCLES = 500000
`endif
) (
   input  logic                            clk,
   input  logic                            initialize,
   input  logic [2:0]                      state,
   input  logic                            digit_valid,
   input  logic [3:0]                      digit,
   output logic                            correct,
   output logic [$clog2(MAX_DIGITS+1)-1:0] entry_count,
   output logic [4*MAX_DIGITS-1:0]         entry_bus
);

   localparam int CW = $clog2(MAX_DIGITS+1);
   localparam int BW = 4*MAX_DIGITS;

   typedef enum logic [2:0] {
      ST_OFF    = 3'b000,
      ST_ON     = 3'b001,
      ST_WRONG1 = 3'b010,
      ST_WRONG2 = 3'b011,
      ST_ANSWER = 3'b100,
      ST_RESET  = 3'b101,
      ST_LOCK   = 3'b111
   } sm_state_e;

   sm_state_e         cur_state;
   sm_state_e         prev_state;
   logic [BW-1:0]     passcode;
   logic [CW-1:0]     pw_len;

   logic              state_chg;
   logic              digit_ok;
   logic              timeout_hit;
   logic              commit;
   logic [BW-1:0]     next_buf;
   logic [CW-1:0]     next_cnt;
   logic              next_correct;

`ifdef PASSCODE_TIMEOUT_EN
   localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [IW-1:0] idle_cnt;

   always_ff @(posedge clk) begin
      if (initialize || state_chg || timeout_hit || digit_ok) begin
         idle_cnt <= '0;
      end else if (entry_count != '0) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign timeout_hit = (idle_cnt == IW'(TIMEOUT_CYCLES-1));
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: every signal written in this block gets a default first, so no latch is inferred.
   always_comb begin
      cur_state = sm_state_e'(state);
      state_chg = (cur_state != prev_state);
      digit_ok  = digit_valid && (digit <= 4'd9) && (entry_count < CW'(MAX_DIGITS)) &&
                  (cur_state inside {ST_ON, ST_WRONG1, ST_WRONG2, ST_RESET});
      commit    = (prev_state == ST_RESET) && (cur_state == ST_OFF) &&
                  (entry_count >= CW'(MIN_LEN)) && !timeout_hit;

      next_buf = entry_bus;
      next_cnt = entry_count;
      // A state change or timeout wins over a digit arriving in the same cycle.
      if (state_chg || timeout_hit) begin
         next_buf = '0;
         next_cnt = '0;
      end else if (digit_ok) begin
         next_buf = {entry_bus[BW-5:0], digit};
         next_cnt = entry_count + 1'b1;
      end

      next_correct = 1'b0;
      case (cur_state)
         ST_ON, ST_WRONG1, ST_WRONG2: next_correct = (next_cnt == pw_len) && (next_buf == passcode);
         ST_RESET:                    next_correct = (next_cnt >= CW'(MIN_LEN));
         default:                     next_correct = 1'b0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (initialize) begin
         entry_bus   <= '0;
         entry_count <= '0;
         correct     <= 1'b0;
         prev_state  <= ST_OFF;
         passcode    <= DEFAULT_PW;
         pw_len      <= CW'(DEFAULT_LEN);
      end else begin
         entry_bus   <= next_buf;
         entry_count <= next_cnt;
         correct     <= next_correct;
         prev_state  <= cur_state;
         if (commit) begin
            passcode <= entry_bus;
            pw_len   <= entry_count;
         end
      end
   end

endmodule

// File: tb/tb_passcode_checker.sv
// Directed self-checking bench for passcode_checker (default build, timeout disabled).
module tb_passcode_checker;

   logic       clk = 1'b0;
   logic       initialize;
   logic [2:0] state;
   logic       digit_valid;
   logic [3:0] digit;
   logic       correct;
   logic [3:0] entry_count;
   logic [31:0] entry_bus;

   int n_checks = 0;
   int n_errors = 0;

   passcode_checker dut (
      .clk         (clk),
      .initialize  (initialize),
      .state       (state),
      .digit_valid (digit_valid),
      .digit       (digit),
      .correct     (correct),
      .entry_count (entry_count),
      .entry_bus   (entry_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] d);
      @(negedge clk);
      digit_valid = 1'b1;
      digit       = d;
      @(negedge clk);
      digit_valid = 1'b0;
   endtask

   task automatic set_state(input logic [2:0] s);
      @(negedge clk);
      state = s;
      @(negedge clk);
   endtask

   task automatic press_seq(input logic [31:0] seq, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         logic [31:0] tmp;
         tmp = seq >> (4 * i);
         press(tmp[3:0]);
      end
   endtask

   initial begin
      initialize  = 1'b1;
      state       = 3'b000;
      digit_valid = 1'b0;
      digit       = 4'd0;
      repeat (2) @(negedge clk);
      initialize = 1'b0;
      check("reset_count",   entry_count, 0);
      check("reset_correct", correct,     0);
      check("reset_bus",     entry_bus,   0);

      // Factory passcode 1234
      set_state(3'b001);
      press_seq(32'h123, 3);
      check("partial_correct", correct, 0);
      press(4'd4);
      check("p1234_bus",     entry_bus,   32'h0000_1234);
      check("p1234_count",   entry_count, 4);
      check("p1234_correct", correct,     1);
      repeat (3) @(negedge clk);
      check("p1234_hold", correct, 1);
      press(4'd5);
      check("p5_bus",     entry_bus, 32'h0001_2345);
      check("p5_correct", correct,   0);

      // Wrong entry, then state change clears
      set_state(3'b000);
      set_state(3'b001);
      press_seq(32'h9999, 4);
      check("p9999_count",   entry_count, 4);
      check("p9999_correct", correct,     0);
      set_state(3'b010);
      check("chg_count",   entry_count, 0);
      check("chg_bus",     entry_bus,   0);
      check("chg_correct", correct,     0);

      // Digit on a state-change cycle is dropped
      @(negedge clk);
      state       = 3'b011;
      digit_valid = 1'b1;
      digit       = 4'd7;
      @(negedge clk);
      digit_valid = 1'b0;
      check("chg_drop_count", entry_count, 0);

      // New passcode 5678
      set_state(3'b101);
      press_seq(32'h567, 3);
      check("rst3_correct", correct, 0);
      press(4'd8);
      check("rst4_correct", correct,     1);
      check("rst4_count",   entry_count, 4);
      set_state(3'b000);
      check("commit_count",   entry_count, 0);
      check("commit_correct", correct,     0);
      set_state(3'b001);
      press_seq(32'h1234, 4);
      check("old_pw_correct", correct, 0);
      set_state(3'b010);
      press_seq(32'h5678, 4);
      check("new_pw_correct", correct, 1);

      // initialize restores factory passcode
      @(negedge clk);
      initialize = 1'b1;
      state      = 3'b000;
      @(negedge clk);
      initialize = 1'b0;
      check("init_count",   entry_count, 0);
      check("init_correct", correct,     0);
      set_state(3'b001);
      press_seq(32'h1234, 4);
      check("init_pw_correct", correct, 1);

      // Short new passcode is not committed
      set_state(3'b101);
      press_seq(32'h567, 3);
      check("short_count", entry_count, 3);
      set_state(3'b000);
      set_state(3'b001);
      press_seq(32'h1234, 4);
      check("nocommit_correct", correct, 1);

      // Non-BCD digits, saturation, ignoring states
      set_state(3'b000);
      set_state(3'b001);
      press(4'hA);
      check("nonbcd_empty", entry_count, 0);
      press(4'd1);
      press(4'hF);
      check("nonbcd_count", entry_count, 1);
      check("nonbcd_bus",   entry_bus,   32'h0000_0001);
      press_seq(32'h2345_6789, 8);
      press(4'd0);
      check("sat_count",   entry_count, 8);
      check("sat_bus",     entry_bus,   32'h1234_5678);
      check("sat_correct", correct,     0);
      set_state(3'b111);
      press(4'd3);
      check("lock_count",   entry_count, 0);
      check("lock_correct", correct,     0);
      set_state(3'b100);
      press(4'd3);
      check("answer_count", entry_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
